store_narrow_buffer: RTL
========================

# store_narrow_buffer

Store-path write formatter for the CPU data-memory port. It takes a 32-bit register value plus a byte address and an access size (sb/sh/sw), narrows and lane-replicates the data, and generates word-aligned addresses and byte enables. Formatted stores are queued in a small FIFO and drained to data memory over a valid/ready handshake. Misaligned or reserved-size requests are rejected and reported.

## Interface
Parameters:
- DEPTH, 2, number of FIFO entries; power of two, ≥2

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  request accepted on edge where req_valid & req_ready
- req_addr  in  32  byte address
- req_data  in  32  register (rt) value
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- mem_valid  out  1  head entry present
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
- err_misalign  out  1  one-cycle pulse: request rejected
- err_addr  out  32  req_addr of the most recent rejected request
- busy  out  1  FIFO non-empty (same as mem_valid)

## Operation
- Formatting, from req_size and addr[1:0]:
  - Byte: wdata = {4{data[7:0]}}, be = 4'b0001 << addr[1:0]; always aligned.
  - Halfword: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011; legal only if addr[0]==0.
  - Word: wdata = data, be = 4'b1111; legal only if addr[1:0]==0.
  - mem_addr = {req_addr[31:2], 2'b00}.
- Illegal requests are misaligned halfword/word or size 11.
  - They are still accepted when req_ready is high.
  - They are not enqueued.
  - err_misalign pulses and err_addr loads req_addr.
- FIFO:
  - Circular; read/write pointers wrap modulo DEPTH; count is 0..DEPTH.
  - Enqueue on a legal accepted request.
  - Dequeue on mem_valid & mem_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- req_ready = (count != DEPTH). It is combinational from registered count only and never depends on req_valid.
- mem_valid = (count != 0). mem_addr, mem_wdata and mem_be come from the head entry.
- Entries drain strictly in acceptance order.

## Timing
- Reset (rstn low, asynchronous):
  - count = 0, pointers = 0.
  - mem_valid = 0, busy = 0, req_ready = 1.
  - mem_addr / mem_wdata / mem_be = 0.
  - err_misalign = 0, err_addr = 0.
- Reset mid-operation discards all queued entries; no partial drain after release.
- Latency: a legal request accepted at edge N appears on mem_* with mem_valid = 1 after edge N. There is no combinational pass-through.
- err_misalign is high for exactly the cycle after the accepting edge. Back-to-back illegal requests give consecutive pulses, and err_addr updates each cycle.
- Mem-side payload and mem_valid are held stable while mem_valid & !mem_ready.
- Full (count == DEPTH):
  - req_ready = 0, so no enqueue, including illegal requests; no error pulse.
  - A dequeue at edge N raises req_ready after edge N.
- Empty with an enqueue at edge N: mem_valid rises after N.
- A same-edge dequeue of the last entry and enqueue of a new one keeps mem_valid = 1 and presents the new entry.
- Throughput: one enqueue and one dequeue per cycle sustained with mem_ready held high.

## Test plan
- Reset values: assert rstn=0 mid-stream with 2 entries queued. Required: mem_valid=0, req_ready=1, err_addr=0; after release the first new store appears alone.
- Byte lanes: sb of data 0x123456AB to addrs 0x100..0x103 with mem_ready=1.
  - Required: mem_addr=0x100 and wdata=0xABABABAB for all four.
  - Required be sequence: 0001, 0010, 0100, 1000, each one cycle after acceptance.
- Halfword and word: sh 0xCAFEBEEF @0x202 gives be=1100, wdata=0xBEEFBEEF, mem_addr=0x200. sw 0xDEADBEEF @0x204 gives be=1111, wdata=0xDEADBEEF.
- Misalignment: sh @0x301, sw @0x302, and size=11 @0x400, back-to-back.
  - Required: nothing enqueued, mem_valid stays 0.
  - Required: err_misalign high for 3 consecutive cycles, err_addr 0x301, 0x302, 0x400.
- Full/backpressure: DEPTH=2, mem_ready=0, issue 3 legal stores A, B, C.
  - Required: A and B accepted; req_ready=0 with C held; mem payload stable on A.
  - Then mem_ready=1: drain order A, B, C, with C accepted the cycle after A drains.
- Simultaneous: count=1, mem_ready=1, new legal request on the same edge. Required: count stays 1, next head is the new entry, no bubble on mem_valid.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// Store-path write formatter: narrows and lane-replicates register data, builds
// word address and byte enables, and queues legal stores toward data memory.
module store_narrow_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        err_misalign,
  output logic [31:0] err_addr,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a transfer happens on the rising edge where valid & ready are
  // both high; ready never looks at valid, and a valid side holds its payload
  // stable until that edge.

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [29:0]   ent_addr  [DEPTH];
  logic [31:0]   ent_wdata [DEPTH];
  logic [3:0]    ent_be    [DEPTH];

  logic        legal;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic        accept, enq, deq;

  always_comb begin
    legal     = 1'b0;
    fmt_wdata = '0;
    fmt_be    = '0;
    case (req_size)
      2'b00: begin
        legal     = 1'b1;
        fmt_wdata = {4{req_data[7:0]}};
        fmt_be    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        legal     = ~req_addr[0];
        fmt_wdata = {2{req_data[15:0]}};
        fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal     = (req_addr[1:0] == 2'b00);
        fmt_wdata = req_data;
        fmt_be    = 4'b1111;
      end
      default: begin
        legal     = 1'b0;
        fmt_wdata = '0;
        fmt_be    = '0;
      end
    endcase
  end

  assign req_ready = (count != FULL);
  assign mem_valid = (count != '0);
  assign busy      = mem_valid;
  assign accept    = req_valid & req_ready;
  assign enq       = accept & legal;
  assign deq       = mem_valid & mem_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr]  <= req_addr[31:2];
      ent_wdata[wr_ptr] <= fmt_wdata;
      ent_be[wr_ptr]    <= fmt_be;
    end
  end

  // Payload is forced to zero when empty so stale slots never show after reset.
  assign mem_addr  = mem_valid ? {ent_addr[rd_ptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? ent_wdata[rd_ptr] : 32'h0;
  assign mem_be    = mem_valid ? ent_be[rd_ptr] : 4'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_misalign <= 1'b0;
      err_addr     <= '0;
    end else begin
      err_misalign <= accept & ~legal;
      if (accept & ~legal) err_addr <= req_addr;
    end
  end

endmodule
